// File: rtl/kyber_pkg.sv
// Purpose: shared constants and types for the Kyber modular-multiplier slice.
//   KYBER_W   coefficient width (Q < 2**W)
//   KYBER_Q   Kyber modulus
//   BARRETT_M floor(2**BARRETT_K / KYBER_Q)
//   BARRETT_K Barrett shift
package kyber_pkg;
    localparam int KYBER_W   = 12;
    localparam int KYBER_Q   = 3329;
    localparam int BARRETT_M = 5039;
    localparam int BARRETT_K = 24;

    typedef logic [KYBER_W-1:0]   coeff_t;
    typedef logic [2*KYBER_W-1:0] prod_t;
endpackage

// File: rtl/kyber_barrett_comb.sv
// Purpose: combinational Barrett reduction of a 2W-bit product to a W-bit residue.
// Ports:
//   p_i  in  2W  product, expected < Q*Q for an exact residue
//   r_o  out W   p_i mod Q when p_i < Q*Q; otherwise some value < 2**W
module kyber_barrett_comb
    import kyber_pkg::*;
#(
    parameter int W     = KYBER_W,
    parameter int Q     = KYBER_Q,
    parameter int BAR_M = BARRETT_M,
    parameter int BAR_K = BARRETT_K
) (
    input  logic [2*W-1:0] p_i,
    output logic [W-1:0]   r_o
);
    // Wide enough for p * BAR_M without overflow (BAR_M < 2**13).
    localparam int XW = 2 * W + 14;
    localparam logic [W:0] Q_X = (W + 1)'(Q);

    logic [XW-1:0] p_x;
    logic [XW-1:0] pm;
    logic [XW-1:0] t;
    logic [XW-1:0] tq;
    logic [W:0]    r0;

    assign p_x = XW'(p_i);
    assign pm  = p_x * XW'(BAR_M);
    assign t   = pm >> BAR_K;
    assign tq  = t * XW'(Q);
    // For p < Q*Q the estimate t is short by at most one, so r0 < 2Q fits W+1 bits.
    assign r0  = (W + 1)'(p_x - tq);
    assign r_o = W'((r0 >= Q_X) ? (r0 - Q_X) : r0);
endmodule

// File: rtl/kyber_modmul_pipe.sv
// Purpose: 3-stage streaming a*b mod Q with optional burst accumulation.
// Ports:
//   clk_i, rst_i               clock (rising) and async active-high reset
//   in_valid_i / in_ready_o    operand handshake; a_i, b_i, acc_i, last_i travel with it
//   out_valid_o / out_ready_i  result handshake; result_o < 2**W always
//   range_err_o                sticky flag: an accepted operand was >= Q
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
//   A producer holds its payload while valid & !ready. One enable (en) advances every
//   stage together, so a stalled output freezes the whole pipe and nothing is lost.
module kyber_modmul_pipe
    import kyber_pkg::*;
#(
    parameter int W     = KYBER_W,
    parameter int Q     = KYBER_Q,
    parameter int BAR_M = BARRETT_M,
    parameter int BAR_K = BARRETT_K
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         acc_i,
    input  logic         last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] result_o,
    output logic         range_err_o
);
    localparam logic [W-1:0] Q_C = W'(Q);
    localparam logic [W:0]   Q_X = (W + 1)'(Q);

    // S1: registered operands
    logic           v1_q, v1_d;
    logic [W-1:0]   a1_q, a1_d, b1_q, b1_d;
    logic           acc1_q, acc1_d, last1_q, last1_d;
    // S2: registered product
    logic           v2_q, v2_d;
    logic [2*W-1:0] p2_q, p2_d;
    logic           acc2_q, acc2_d, last2_q, last2_d;
    // S3: output register, running sum, error flag
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   acc_sum_q, acc_sum_d;
    logic           range_err_q, range_err_d;

    logic           en;
    logic [W-1:0]   r;
    logic [W:0]     sum_full;
    logic [W-1:0]   sum_mod;

    assign en = !out_valid_q || out_ready_i;

    kyber_barrett_comb #(
        .W     (W),
        .Q     (Q),
        .BAR_M (BAR_M),
        .BAR_K (BAR_K)
    ) u_barrett (
        .p_i (p2_q),
        .r_o (r)
    );

    // Modular add of the running sum and the new residue; one subtract suffices
    // since both terms are < Q for in-range operands.
    assign sum_full = {1'b0, acc_sum_q} + {1'b0, r};
    assign sum_mod  = W'((sum_full >= Q_X) ? (sum_full - Q_X) : sum_full);

    always_comb begin
        v1_d        = v1_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        acc1_d      = acc1_q;
        last1_d     = last1_q;
        v2_d        = v2_q;
        p2_d        = p2_q;
        acc2_d      = acc2_q;
        last2_d     = last2_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        acc_sum_d   = acc_sum_q;
        range_err_d = range_err_q;

        if (in_valid_i && en && ((a_i >= Q_C) || (b_i >= Q_C))) begin
            range_err_d = 1'b1;
        end

        if (en) begin
            v1_d    = in_valid_i;
            a1_d    = a_i;
            b1_d    = b_i;
            acc1_d  = acc_i;
            last1_d = last_i;

            v2_d    = v1_q;
            p2_d    = {{W{1'b0}}, a1_q} * {{W{1'b0}}, b1_q};
            acc2_d  = acc1_q;
            last2_d = last1_q;

            // Non-final burst terms only update the sum and produce no output beat.
            out_valid_d = v2_q && (!acc2_q || last2_q);
            if (v2_q) begin
                if (!acc2_q) begin
                    result_d = r;
                end else if (last2_q) begin
                    result_d  = sum_mod;
                    acc_sum_d = '0;
                end else begin
                    acc_sum_d = sum_mod;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            acc1_q      <= 1'b0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            p2_q        <= '0;
            acc2_q      <= 1'b0;
            last2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_sum_q   <= '0;
            range_err_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            acc1_q      <= acc1_d;
            last1_q     <= last1_d;
            v2_q        <= v2_d;
            p2_q        <= p2_d;
            acc2_q      <= acc2_d;
            last2_q     <= last2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_sum_q   <= acc_sum_d;
            range_err_q <= range_err_d;
        end
    end

    assign in_ready_o  = en;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign range_err_o = range_err_q;
endmodule

// File: tb/tb_kyber_modmul_pipe.sv
module tb_kyber_modmul_pipe;
    localparam int Q = 3329;

    logic        clk_i;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] a_i;
    logic [11:0] b_i;
    logic        acc_i;
    logic        last_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [11:0] result_o;
    logic        range_err_o;

    kyber_modmul_pipe dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .acc_i       (acc_i),
        .last_i      (last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .range_err_o (range_err_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // bit 12 set = result value is don't-care (out-of-range operand)
    logic [12:0] exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  acc_m = 0;
    bit  rand_bp = 0;
    int  fire_cnt = 0;
    int  first_cyc = 0;
    int  last_cyc = 0;
    bit  prev_stall = 0;
    logic [11:0] prev_result = '0;

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Output monitor: sampled on the falling edge, a beat transfers at the next rising edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", int'(out_valid_o), 1);
                check("stall_result_hold", int'(result_o), int'(prev_result));
            end
            if (out_valid_o && out_ready_i) begin
                fire_cnt++;
                if (fire_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    if (!e[12]) check("result", int'(result_o), int'(e[11:0]));
                end
            end
            prev_stall  = out_valid_o && !out_ready_i;
            prev_result = result_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_bp) out_ready_i = 1'($urandom_range(0, 1));
    endtask

    // Present one operand pair, wait for acceptance, then record the expected emission.
    task automatic send(input int a, input int b, input bit acc, input bit last,
                        input bit use_exp, input int exp_v, input bit dc);
        bit got;
        int prod;
        int val;
        bit emit;
        a_i        = 12'(a);
        b_i        = 12'(b);
        acc_i      = acc;
        last_i     = last;
        in_valid_i = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk_i);
            got = in_ready_o;
            tick();
        end
        in_valid_i = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
        prod = (a * b) % Q;
        emit = 0;
        val  = 0;
        if (!acc) begin
            val  = prod;
            emit = 1;
        end else begin
            acc_m = (acc_m + prod) % Q;
            if (last) begin
                val   = acc_m;
                acc_m = 0;
                emit  = 1;
            end
        end
        if (emit) exp_q.push_back({dc, use_exp ? 12'(exp_v) : 12'(val)});
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int a;
        int b;
        bit acc;
        bit last;
        int exp_v;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{17, 1000, 0, 0, 355};
        vecs[1]  = '{3328, 3328, 0, 0, 1};
        vecs[2]  = '{0, 1234, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 1};
        vecs[4]  = '{3328, 1, 0, 0, 3328};
        vecs[5]  = '{1665, 2, 0, 0, 1};
        vecs[6]  = '{3328, 2, 0, 0, 3327};
        vecs[7]  = '{2, 3, 0, 1, 6};      // last ignored without acc
        vecs[8]  = '{5, 5, 1, 0, 0};      // burst term, no emission
        vecs[9]  = '{2, 2, 0, 0, 4};      // plain product mid-burst
        vecs[10] = '{3, 3, 1, 1, 34};     // 25 + 9
        vecs[11] = '{1000, 1000, 0, 0, 1300};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        acc_i       = 1'b0;
        last_i      = 1'b0;
        out_ready_i = 1'b1;

        @(negedge clk_i);
        check("reset_out_valid", int'(out_valid_o), 0);
        check("reset_result", int'(result_o), 0);
        check("reset_range_err", int'(range_err_o), 0);
        check("reset_in_ready", int'(in_ready_o), 1);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();

        // Latency: accept edge, then two more edges before out_valid_o rises.
        a_i = 12'd17; b_i = 12'd1000; acc_i = 0; last_i = 0; in_valid_i = 1;
        @(negedge clk_i);
        check("lat_in_ready", int'(in_ready_o), 1);
        @(posedge clk_i);
        #1 in_valid_i = 0;
        exp_q.push_back({1'b0, 12'd355});
        @(negedge clk_i);
        check("lat_c1_valid", int'(out_valid_o), 0);
        @(negedge clk_i);
        check("lat_c2_valid", int'(out_valid_o), 0);
        @(negedge clk_i);
        check("lat_c3_valid", int'(out_valid_o), 1);
        check("lat_c3_result", int'(result_o), 355);
        tick();
        drain();

        // Table vectors back-to-back
        for (int i = 0; i < 12; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].last, 1, vecs[i].exp_v, 0);
        drain();

        // Bursts: (3328*3328 + 3328*1) mod Q = 0, then single-term burst 2*3 = 6
        send(3328, 3328, 1, 0, 0, 0, 0);
        send(3328, 1, 1, 1, 1, 0, 0);
        send(2, 3, 1, 1, 1, 6, 0);
        drain();

        // Backpressure: three in flight, output stalled five cycles
        out_ready_i = 1'b0;
        send(100, 200, 0, 0, 0, 0, 0);
        send(3000, 3001, 0, 0, 0, 0, 0);
        send(7, 9, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("bp_in_ready", int'(in_ready_o), 0);
            check("bp_out_valid", int'(out_valid_o), 1);
            check("bp_result", int'(result_o), (100 * 200) % Q);
            tick();
        end
        out_ready_i = 1'b1;
        drain();

        // 1000 random pairs at full rate
        fire_cnt = 0;
        for (int i = 0; i < 1000; i++)
            send($urandom_range(0, Q - 1), $urandom_range(0, Q - 1), 0, 0, 0, 0, 0);
        drain();
        check("rand_count", fire_cnt, 1000);
        check("rand_rate", last_cyc - first_cyc, 999);

        // Random bursts with random backpressure
        rand_bp = 1;
        for (int i = 0; i < 300; i++) begin
            bit acc;
            acc = 1'($urandom_range(0, 1));
            send($urandom_range(0, Q - 1), $urandom_range(0, Q - 1), acc,
                 acc ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1)), 0, 0, 0);
        end
        send($urandom_range(0, Q - 1), $urandom_range(0, Q - 1), 1, 1, 0, 0, 0);
        rand_bp = 0;
        out_ready_i = 1'b1;
        drain();

        // Range error is sticky until reset
        check("rerr_before", int'(range_err_o), 0);
        send(3329, 5, 0, 0, 0, 0, 1);
        @(negedge clk_i);
        check("rerr_set", int'(range_err_o), 1);
        tick();
        send(1, 1, 0, 0, 0, 0, 0);
        drain();
        check("rerr_sticky", int'(range_err_o), 1);

        // Reset mid-stream with results in flight and a partial sum
        send(11, 12, 1, 0, 0, 0, 0);
        send(13, 14, 0, 0, 0, 0, 0);
        send(15, 16, 0, 0, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid_valid", int'(out_valid_o), 0);
        check("rst_mid_rerr", int'(range_err_o), 0);
        check("rst_mid_result", int'(result_o), 0);
        exp_q.delete();
        acc_m = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("post_rst_idle", int'(out_valid_o), 0);
        end
        tick();

        // Partial sum discarded: a fresh single-term burst emits only its own product
        send(2, 5, 1, 1, 1, 10, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
